// File: rtl/ps2_keyboard_mmio_if.sv
// Data-bus port between the CPU address decoder and the PS/2 keyboard peripheral.
// rdata is combinational from the slave.
interface ps2_keyboard_mmio_if;
  logic        req;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, input rdata);
  modport slave  (input req, we, addr, wdata, output rdata);
endinterface

// File: rtl/ps2_keyboard_mmio.sv
// PS/2 keyboard receiver: pin synchroniser, 11-bit frame deframer with timeout,
// scancode FIFO and a memory-mapped DATA/STATUS/CTRL register block with interrupt.
module ps2_keyboard_mmio #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 ps2_clk_i,
  input  logic                 ps2_data_i,
  ps2_keyboard_mmio_if.slave   bus,
  output logic                 int_req_o,
  input  logic                 int_fin_i,
  output logic [7:0]           last_key_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_t;

  logic          clk_s1_q, clk_s2_q, clk_h_q, dat_s1_q, dat_s2_q;
  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          perr_q, perr_d, ovf_q, ovf_d, ie_q, ie_d, pend_q, pend_d;
  logic [7:0]    last_q, last_d;

  logic fall, push_try, frame_err, rd, wr, empty, full, pop, push_ok;
  logic [31:0] rdata_c;
  logic unused_wdata;

  assign fall  = clk_h_q & ~clk_s2_q;
  assign rd    = bus.req & ~bus.we;
  assign wr    = bus.req & bus.we;
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign pop   = rd & (bus.addr == 2'd0) & ~empty;
  // A push into a full FIFO still succeeds when a pop frees a slot in the same cycle.
  assign push_ok = push_try & (~full | pop);
  assign unused_wdata = ^bus.wdata[31:3];

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    to_cnt_d  = '0;
    push_try  = 1'b0;
    frame_err = 1'b0;
    if (fall) begin
      case (state_q)
        ST_IDLE: if (!dat_s2_q) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
        ST_DATA: begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_d   = dat_s2_q;
          state_d = ST_STOP;
        end
        default: begin
          if (dat_s2_q && (^{shift_q, par_q})) push_try = 1'b1;
          else frame_err = 1'b1;
          state_d = ST_IDLE;
        end
      endcase
    end else if (state_q != ST_IDLE) begin
      // Abandon a partial frame silently once the PS/2 clock has been quiet too long.
      if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) state_d = ST_IDLE;
      else to_cnt_d = to_cnt_q + TW'(1);
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    last_d   = last_q;
    perr_d   = perr_q;
    ovf_d    = ovf_q;
    ie_d     = ie_q;
    pend_d   = pend_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = shift_q;
      wr_ptr_d        = wr_ptr_q + AW'(1);
      last_d          = shift_q;
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(push_ok) - CW'(pop);
    if (wr && bus.addr == 2'd1) begin
      if (bus.wdata[1]) perr_d = 1'b0;
      if (bus.wdata[2]) ovf_d  = 1'b0;
    end
    if (wr && bus.addr == 2'd2) ie_d = bus.wdata[0];
    if (frame_err) perr_d = 1'b1;
    if (push_try && full && !pop) ovf_d = 1'b1;
    if (int_fin_i || (wr && bus.addr == 2'd2 && !bus.wdata[0])) pend_d = 1'b0;
    if (push_ok && ie_q) pend_d = 1'b1;
  end

  always_comb begin
    rdata_c = '0;
    if (rd) begin
      case (bus.addr)
        2'd0:    if (!empty) rdata_c = {24'b0, mem_q[rd_ptr_q]};
        2'd1:    rdata_c = {16'b0, 8'(count_q), 5'b0, ovf_q, perr_q, ~empty};
        2'd2:    rdata_c = {31'b0, ie_q};
        default: rdata_c = '0;
      endcase
    end
  end

  assign bus.rdata  = rdata_c;
  assign int_req_o  = pend_q;
  assign last_key_o = last_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      clk_s1_q  <= 1'b0;
      clk_s2_q  <= 1'b0;
      clk_h_q   <= 1'b0;
      dat_s1_q  <= 1'b0;
      dat_s2_q  <= 1'b0;
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      to_cnt_q  <= '0;
      mem_q     <= '{default: '0};
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      perr_q    <= 1'b0;
      ovf_q     <= 1'b0;
      ie_q      <= 1'b0;
      pend_q    <= 1'b0;
      last_q    <= '0;
    end else begin
      clk_s1_q  <= ps2_clk_i;
      clk_s2_q  <= clk_s1_q;
      clk_h_q   <= clk_s2_q;
      dat_s1_q  <= ps2_data_i;
      dat_s2_q  <= dat_s1_q;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      to_cnt_q  <= to_cnt_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      perr_q    <= perr_d;
      ovf_q     <= ovf_d;
      ie_q      <= ie_d;
      pend_q    <= pend_d;
      last_q    <= last_d;
    end
  end
endmodule
